router_1xn_core: RTL and testbench
==================================

// Module: router_1xn_core
// PURPOSE
//  Parametrised 1-to-N packet router core; successor to the fixed 1x3 router, generalised in data width, channel count and FIFO depth.
//  - Accepts byte-serial packets (header, payload, parity) on one source port; steers each packet to one of N output FIFOs by header address.
//  - Checks parity; flushes any channel whose reader stalls too long.
//  - Sits between the source write agent and N destination read agents.
// PARAMETERS
//  DATA_W   8   width of data_in/data_out and header byte
//  N_CH     3   number of destination channels (2..16)
//  DEPTH    16  words per channel FIFO, power of 2
//  TIMEOUT  30  cycles vld_out[i]=1 with read_enb[i]=0 before channel i is flushed
// PORTS
//  clock     in   1             rising-edge clock
//  resetn    in   1             async active-low reset
//  data_in   in   DATA_W        header/payload/parity byte
//  pkt_valid in   1             high for header+payload bytes; low on the parity byte
//  busy      out  1             source must hold data_in/pkt_valid while high
//  err       out  1             parity or address error on last packet
//  read_enb  in   N_CH          per-channel read request
//  data_out  out  N_CH*DATA_W   per-channel read data, channel i at [i*DATA_W +: DATA_W]
//  vld_out   out  N_CH          per-channel FIFO not empty
// BEHAVIOUR
//  - Reset (async, resetn=0): all outputs 0, FIFOs empty, FSM in IDLE, timeout counters 0.
//  - Header fields: AW=$clog2(N_CH); addr=data_in[AW-1:0]; len=data_in[DATA_W-1:AW] (payload bytes, 0 legal).
//  - Byte acceptance: on a clock edge with busy=0. The header is pkt_valid=1 in IDLE.
//  - Parity byte: the first accepted byte with pkt_valid=0 after the header.
//  - FSM states, with transitions:
//    - IDLE: header accepted and addr<N_CH -> LOAD_DATA; addr>=N_CH -> DROP.
//    - LOAD_DATA: each accepted byte written to FIFO[addr]; pkt_valid=0 byte -> CHECK_PARITY.
//    - CHECK_PARITY: one cycle; parity byte written; err updated -> IDLE.
//    - DROP: bytes consumed, nothing written; parity byte -> IDLE with err=1.
//  - busy (combinational from state and flags) is 1 when any of:
//    - IDLE with pkt_valid=1 and full[data_in addr];
//    - LOAD_DATA with full[addr];
//    - CHECK_PARITY.
//    The bytes to be stored are header, payload and parity; busy is never 1 in DROP.
//  - Parity: running XOR of header and payload bytes. err register:
//    - set to (computed != received parity) in CHECK_PARITY;
//    - set to 1 on DROP exit;
//    - cleared when the next header is accepted;
//    - otherwise held.
//  - Length is informational; packet end is defined by pkt_valid only. No length check.
//  - FIFO i, read side:
//    - read_enb[i]=1 and not empty: data_out[i] loads the head word on the next edge (1-cycle latency); otherwise data_out[i] holds.
//    - vld_out[i] = !empty[i].
//  - FIFO i, simultaneous read+write: both happen; count unchanged. Writing while full cannot occur (busy).
//  - FIFO i, pointers: wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - Timeout: counter[i] increments while vld_out[i]=1 and read_enb[i]=0, and clears otherwise.
//  - Timeout at TIMEOUT: the soft flush of FIFO i runs on that edge (pointers/count=0; data_out[i] holds) and the counter clears.
//  - Flush during an active packet to channel i: flush wins; the FSM goes to DROP; rest of the packet is discarded; err=1 at its end.
//  - resetn assertion mid-packet: immediate return to reset state. The source must restart from a header.
// STRUCTURE
//  - router_pkg holds:
//    - state_e enum {IDLE, LOAD_DATA, CHECK_PARITY, DROP};
//    - default parameter constants;
//    - functions hdr_addr() and hdr_len().
//  - One sub-module, router_chan_fifo (DATA_W, DEPTH, TIMEOUT), instantiated N_CH times via generate. It holds storage, registered data_out, full/empty and the timeout/flush logic, plus a flush_o pulse to the core FSM.
//  - The core holds the FSM, parity register, err and busy.
// TESTING (N_CH=3, DATA_W=8, DEPTH=16, TIMEOUT=30)
//  1. Header 8'h0D (ch1, len3), payload 11,22,33, parity 8'h0D^11^22^33 -> 5 words in FIFO1, vld_out=3'b010, err=0; read_enb[1] held 5 cycles returns bytes in order with 1-cycle latency.
//  2. Same packet with parity inverted -> err=1 the cycle after the parity byte, cleared on the next accepted header.
//  3. Header 8'h03 (addr 3 invalid) -> no FIFO writes, vld_out=0, busy=0 throughout, err=1 after the parity byte.
//  4. 20-byte packet to ch0 with read_enb=0 -> busy rises after 16 writes; assert read_enb[0] -> busy drops, all bytes delivered intact.
//  5. Packet to ch2, read_enb[2]=0 -> FIFO2 flushed exactly 30 cycles after vld_out[2] rose; vld_out[2]=0. Read after 29 cycles instead -> no flush.
//  6. resetn pulsed low mid-payload -> all outputs 0 immediately; a fresh packet afterwards routes correctly.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared FSM type, default parameters and header field helpers for router_1xn_core.
package router_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_DATA, CHECK_PARITY, DROP} state_e;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_N_CH    = 3;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 30;
    function automatic int hdr_addr(input int hdr, input int aw);
        return hdr & ((1 << aw) - 1);
    endfunction
    function automatic int hdr_len(input int hdr, input int aw);
        return hdr >> aw;
    endfunction
endpackage

// File: rtl/router_chan_fifo.sv
// router_chan_fifo: one destination channel; FIFO with registered read data and a reader-stall
// timeout that soft-flushes the channel and pulses flush_o to the core.
module router_chan_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              flush_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [TW-1:0] tcnt;
    logic wr, rd;
    assign empty   = cnt == '0;
    assign full    = cnt[PW];
    assign flush_o = !empty && !re && tcnt == TW'(TIMEOUT - 1);
    assign wr      = we && !full && !flush_o;
    assign rd      = re && !empty;
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            data_out <= '0;
        end else begin
            tcnt <= !empty && !re && !flush_o ? tcnt + TW'(1) : '0;
            if (rd) data_out <= mem[rp];
            // flush only fires with re low, so it never races a read
            if (flush_o) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (wr) wp <= wp + PW'(1);
                if (rd) rp <= rp + PW'(1);
                cnt <= cnt + {{PW{1'b0}}, wr} - {{PW{1'b0}}, rd};
            end
        end
    always_ff @(posedge clock)
        if (wr) mem[wp] <= wdata;
endmodule

// File: rtl/router_1xn_core.sv
// router_1xn_core: steers byte-serial packets from one source into N_CH channel FIFOs by header
// address, checking parity and dropping packets with a bad address or a flushed channel.
module router_1xn_core
    import router_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_CH    = DEF_N_CH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   pkt_valid,
    output logic                   busy,
    output logic                   err,
    input  logic [N_CH-1:0]        read_enb,
    output logic [N_CH*DATA_W-1:0] data_out,
    output logic [N_CH-1:0]        vld_out
);
    localparam int AW = $clog2(N_CH);
    localparam int NP = 1 << AW;
    state_e state, next;
    logic [AW-1:0] addr, in_addr, sel;
    logic [DATA_W-1:0] par;
    logic [N_CH-1:0] full, empty, flush, we;
    logic [NP-1:0] full_p, flush_p;
    logic in_ok, hdr_acc, wr;
    assign in_addr = AW'(hdr_addr(int'(data_in), AW));
    assign in_ok   = int'(in_addr) < N_CH;
    // padded copies keep indexing by an out-of-range address legal
    assign full_p  = NP'(full);
    assign flush_p = NP'(flush);
    assign sel     = state == IDLE ? in_addr : addr;
    assign busy    = (state == IDLE && pkt_valid && in_ok && full_p[in_addr]) ||
                     (state == LOAD_DATA && full_p[addr]) || state == CHECK_PARITY;
    assign hdr_acc = state == IDLE && pkt_valid && !busy;
    assign wr      = (hdr_acc && in_ok) || (state == LOAD_DATA && !busy);
    assign we      = wr ? N_CH'(1) << sel : '0;
    always_comb begin
        next = state;
        case (state)
            IDLE:         if (hdr_acc) next = in_ok && !flush_p[in_addr] ? LOAD_DATA : DROP;
            LOAD_DATA:    if (flush_p[addr]) next = !busy && !pkt_valid ? IDLE : DROP;
                          else if (!busy && !pkt_valid) next = CHECK_PARITY;
            CHECK_PARITY: next = IDLE;
            DROP:         if (!pkt_valid) next = IDLE;
            default:      next = IDLE;
        endcase
    end
    // par folds in the received parity byte too, so a clean packet leaves it at zero
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            addr  <= '0;
            par   <= '0;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (hdr_acc) begin
                addr <= in_addr;
                par  <= data_in;
                err  <= 1'b0;
            end else if (state == LOAD_DATA && !busy) par <= par ^ data_in;
            if (state == CHECK_PARITY) err <= par != '0 || flush_p[addr];
            else if (next == IDLE && (state == LOAD_DATA || state == DROP)) err <= 1'b1;
        end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        router_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_fifo (
            .clock    (clock),
            .resetn   (resetn),
            .we       (we[i]),
            .wdata    (data_in),
            .re       (read_enb[i]),
            .data_out (data_out[i*DATA_W +: DATA_W]),
            .full     (full[i]),
            .empty    (empty[i]),
            .flush_o  (flush[i])
        );
        assign vld_out[i] = !empty[i];
    end
endmodule

// File: tb/tb_router_1xn_core.sv
// tb_router_1xn_core: directed and randomized scoreboard bench for router_1xn_core (3 channels).
module tb_router_1xn_core;
    localparam int NCH = 3;
    localparam int TO  = 30;
    logic clock = 0, resetn = 0, pkt_valid = 0;
    logic [7:0] data_in = 0;
    logic [2:0] read_enb = 0;
    logic busy, err;
    logic [23:0] data_out;
    logic [2:0] vld_out;
    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] q [3][$];
    logic [2:0] pend = 0, vld_prev = 0;
    int rise_cyc [3];
    bit rd_rand = 0;

    router_1xn_core #(.DATA_W(8), .N_CH(3), .DEPTH(16), .TIMEOUT(30)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .err       (err),
        .read_enb  (read_enb),
        .data_out  (data_out),
        .vld_out   (vld_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: a read seen on one edge must present the queue head on data_out after that edge
    always @(negedge clock) begin
        if (!resetn) begin
            pend = '0;
            vld_prev = '0;
        end else for (int i = 0; i < NCH; i++) begin
            if (pend[i]) begin
                if (q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch%0d read: got 0x%0h, expected no data", i, data_out[i*8 +: 8]);
                end else chk($sformatf("ch%0d data", i), int'(data_out[i*8 +: 8]), int'(q[i].pop_front()));
            end
            pend[i] = read_enb[i] && vld_out[i];
            if (vld_out[i] && !vld_prev[i]) rise_cyc[i] = cyc;
            vld_prev[i] = vld_out[i];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rd_rand) read_enb = 3'($urandom) | 3'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pv, input int ch, output int waits);
        data_in = d;
        pkt_valid = pv;
        waits = 0;
        forever begin
            @(negedge clock);
            if (!busy) break;
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL accept: byte 0x%0h still blocked by busy after %0d cycles", d, waits);
                break;
            end
            tick();
        end
        if (ch >= 0) q[ch].push_back(d);
        tick();
    endtask

    task automatic send_pkt(input int a, input int len, input bit bad);
        logic [7:0] hdr, par, b;
        int w, wsum, ch;
        hdr = 8'((len << 2) | a);
        ch = a < NCH ? a : -1;
        par = hdr;
        wsum = 0;
        send_byte(hdr, 1'b1, ch, w);
        wsum += w;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            par ^= b;
            send_byte(b, 1'b1, ch, w);
            wsum += w;
        end
        send_byte(bad ? ~par : par, 1'b0, ch, w);
        wsum += w;
        if (ch < 0) chk("drop busy cycles", wsum, 0);
        tick();
        chk("err", int'(err), (ch < 0 || bad) ? 1 : 0);
    endtask

    task automatic drain();
        bit r;
        r = rd_rand;
        rd_rand = 0;
        read_enb = '1;
        for (int k = 0; k < 64 && vld_out != 0; k++) tick();
        tick();
        read_enb = '0;
        chk("drain vld_out", int'(vld_out), 0);
        for (int i = 0; i < NCH; i++) chk($sformatf("ch%0d leftover", i), q[i].size(), 0);
        rd_rand = r;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, wsum;
        logic [7:0] p;
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset err", int'(err), 0);
        chk("reset vld_out", int'(vld_out), 0);
        chk("reset data_out", int'(data_out), 0);
        @(negedge clock);
        resetn = 1;
        tick();

        // ch1, len 3, good parity: 5 words, read back over 5 cycles
        p = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        send_byte(8'h0D, 1'b1, 1, w);
        send_byte(8'h11, 1'b1, 1, w);
        send_byte(8'h22, 1'b1, 1, w);
        send_byte(8'h33, 1'b1, 1, w);
        send_byte(p, 1'b0, 1, w);
        tick();
        chk("t1 err", int'(err), 0);
        chk("t1 vld_out", int'(vld_out), 3'b010);
        read_enb = 3'b010;
        repeat (5) tick();
        read_enb = '0;
        tick();
        chk("t1 empty after 5 reads", int'(vld_out), 0);
        chk("t1 ch1 leftover", q[1].size(), 0);

        // bad parity sets err; next accepted header clears it
        send_byte(8'h0D, 1'b1, 1, w);
        send_byte(8'h11, 1'b1, 1, w);
        send_byte(8'h22, 1'b1, 1, w);
        send_byte(8'h33, 1'b1, 1, w);
        send_byte(~p, 1'b0, 1, w);
        tick();
        chk("t2 err set", int'(err), 1);
        send_byte(8'h05, 1'b1, 1, w);
        chk("t2 err cleared by header", int'(err), 0);
        send_byte(8'h5A, 1'b1, 1, w);
        send_byte(8'h05 ^ 8'h5A, 1'b0, 1, w);
        tick();
        chk("t2 err after good packet", int'(err), 0);
        drain();

        // invalid address
        send_pkt(3, 0, 1'b0);
        chk("t3 vld_out", int'(vld_out), 0);
        send_pkt(3, 2, 1'b0);
        chk("t3 vld_out with payload", int'(vld_out), 0);

        // 20-byte packet to ch0 fills the FIFO after 16 writes
        p = 8'h48;
        wsum = 0;
        send_byte(8'h48, 1'b1, 0, w);
        wsum += w;
        for (int k = 1; k < 16; k++) begin
            p ^= 8'(k * 7);
            send_byte(8'(k * 7), 1'b1, 0, w);
            wsum += w;
        end
        chk("t4 no busy before full", wsum, 0);
        data_in = 8'(16 * 7);
        pkt_valid = 1'b1;
        @(negedge clock);
        chk("t4 busy when full", int'(busy), 1);
        @(posedge clock);
        #1;
        read_enb = 3'b001;
        for (int k = 16; k < 19; k++) begin
            p ^= 8'(k * 7);
            send_byte(8'(k * 7), 1'b1, 0, w);
        end
        send_byte(p, 1'b0, 0, w);
        tick();
        chk("t4 err", int'(err), 0);
        drain();

        // stalled reader on ch2 is flushed exactly TO cycles after vld_out rose
        send_pkt(2, 0, 1'b0);
        for (int k = 0; k < 100 && vld_out[2]; k++) @(negedge clock);
        chk("t5 flush delay", cyc - rise_cyc[2], TO);
        chk("t5 vld_out after flush", int'(vld_out), 0);
        q[2].delete();
        tick();

        // reading on the last cycle before the timeout keeps the data
        send_pkt(2, 1, 1'b0);
        for (int k = 0; k < 100 && cyc != rise_cyc[2] + TO - 1; k++) tick();
        read_enb = 3'b100;
        @(negedge clock);
        chk("t5 vld before timeout edge", int'(vld_out[2]), 1);
        drain();

        // async reset mid-payload, then a fresh packet
        send_byte(8'h0D, 1'b1, 1, w);
        send_byte(8'hAA, 1'b1, 1, w);
        #2;
        resetn = 0;
        pkt_valid = 0;
        #1;
        chk("t6 busy", int'(busy), 0);
        chk("t6 err", int'(err), 0);
        chk("t6 vld_out", int'(vld_out), 0);
        chk("t6 data_out", int'(data_out), 0);
        for (int i = 0; i < NCH; i++) q[i].delete();
        @(negedge clock);
        resetn = 1;
        tick();
        send_pkt(1, 3, 1'b0);
        drain();

        // randomized traffic with random readers
        rd_rand = 1;
        for (int n = 0; n < 60; n++) begin
            send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
